// File: rtl/phy_link_sequencer_pkg.sv
// Shared types and constants for the PHY link sequencer: FSM state encoding,
// default comma symbol and the round-robin pointer wrap helper.
package phy_link_sequencer_pkg;

   typedef enum logic [1:0] {
      RESET   = 2'd0,
      TRAIN   = 2'd1,
      WAIT_RX = 2'd2,
      LINK_UP = 2'd3
   } state_e;

   localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/phy_link_sequencer_if.sv
// Requester bus plus transmit lane between the transaction logic, the sequencer
// and the parallel-to-serial transmitter.
interface phy_link_sequencer_if #(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_en;
   logic [7:0]           tx_data;
   logic                 tx_valid;

   modport master (
      output req_valid, req_data, tx_en,
      input  req_ready, tx_data, tx_valid
   );

   modport slave (
      input  req_valid, req_data, tx_en,
      output req_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/phy_link_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// from NUM_REQ-1 to 0; one-hot grant plus its index.
module phy_link_sequencer_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       gnt_any
);
   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   always_comb begin
      int unsigned j;
      j       = 32'd0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         j = 32'(ptr) + off;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!gnt_any && req[j]) begin
            gnt_any = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = PTR_W'(j);
         end
      end
   end
endmodule

// File: rtl/phy_link_sequencer.sv
// Link bring-up (COM training, wait for far-end receiver) then round-robin byte
// scheduling onto one tx lane, 1-cycle latency. LINK_STATS_EN adds retrain_cnt.
module phy_link_sequencer
   import phy_link_sequencer_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned COM_COUNT   = 4,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter logic [7:0]  COM_SYM     = COM_SYM_DEFAULT
) (
   input  logic                clk_4f,
   input  logic                reset,
   input  logic                rx_active,
   phy_link_sequencer_if.slave lane,
   output logic                link_up,
   output logic [1:0]          state
`ifdef LINK_STATS_EN
   ,
   output logic [7:0]          retrain_cnt
`endif
);
   localparam int unsigned PTR_W   = $clog2(NUM_REQ);
   localparam int unsigned CNT_MAX = (TIMEOUT_CYC > COM_COUNT) ? TIMEOUT_CYC : COM_COUNT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;

   logic [NUM_REQ-1:0] gnt;
   logic [PTR_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [7:0]         sel_dat;
   logic               arb_en;

`ifdef LINK_STATS_EN
   logic [7:0]         retrain_q, retrain_d;
`endif

   phy_link_sequencer_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req     (lane.req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state_q    <= RESET;
         cnt_q      <= '0;
         ptr_q      <= '0;
         tx_data_q  <= COM_SYM;
         tx_valid_q <= 1'b0;
`ifdef LINK_STATS_EN
         retrain_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
`ifdef LINK_STATS_EN
         retrain_q  <= retrain_d;
`endif
      end
   end

   // One counter serves both the COM count in TRAIN and the timeout in WAIT_RX.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RESET: begin
            state_d = TRAIN;
            cnt_d   = '0;
         end
         TRAIN: begin
            if (lane.tx_en) begin
               if (cnt_q == CNT_W'(COM_COUNT - 1)) begin
                  state_d = WAIT_RX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WAIT_RX: begin
            if (rx_active) begin
               state_d = LINK_UP;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d = TRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LINK_UP: begin
            if (!rx_active) begin
               state_d = TRAIN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RESET;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      sel_dat = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_dat = lane.req_data[8*i +: 8];
         end
      end
   end

   // A link drop or a reset in the same cycle suppresses the grant.
   assign arb_en = !reset && (state_q == LINK_UP) && rx_active && lane.tx_en;

   always_comb begin
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      ptr_d      = ptr_q;
      if ((state_q == LINK_UP) && rx_active) begin
         if (lane.tx_en) begin
            if (gnt_any) begin
               tx_data_d  = sel_dat;
               tx_valid_d = 1'b1;
               ptr_d      = PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
            end else begin
               tx_data_d  = COM_SYM;
               tx_valid_d = 1'b0;
            end
         end
      end else begin
         tx_data_d  = COM_SYM;
         tx_valid_d = 1'b0;
      end
   end

`ifdef LINK_STATS_EN
   always_comb begin
      retrain_d = retrain_q;
      if ((state_q == WAIT_RX || state_q == LINK_UP) && state_d == TRAIN &&
          retrain_q != 8'hFF) begin
         retrain_d = retrain_q + 8'd1;
      end
   end

   assign retrain_cnt = retrain_q;
`endif

   assign lane.req_ready = arb_en ? gnt : '0;
   assign lane.tx_data   = tx_data_q;
   assign lane.tx_valid  = tx_valid_q;
   assign link_up        = (state_q == LINK_UP);
   assign state          = state_q;

endmodule
